// File: rtl/decode_issue_ctrl.sv
// In-order issue control: a single issue register fed from the instruction buffer,
// guarded by a per-register pending-writeback scoreboard and a one-deep muldiv busy FSM.
module decode_issue_ctrl #(
    parameter int CNT_W = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fifo_empty,
    output logic        ibuffer_pop,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_uses_rs1,
    input  logic        dec_uses_rs2,
    input  logic        dec_need_to_wb,
    input  logic        dec_is_muldiv,
    input  logic [47:0] dec_pc,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [4:0]  issue_rd,
    output logic        issue_need_to_wb,
    output logic        issue_is_muldiv,
    output logic [47:0] issue_pc,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        md_done,
    input  logic        flush,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MD_BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt [32];

    logic fire, slot_free, fire_acc, md_fire;
    logic rs1_haz, rs2_haz, rd_haz, md_haz, hazard;

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec && c != CNT_MAX) return c + 1'b1;
        if (dec && !inc && c != '0)      return c - 1'b1;
        return c;
    endfunction

    assign fire      = issue_valid & issue_ready;
    assign slot_free = ~issue_valid | fire;
    // A flushed instruction is discarded, so it neither books a writeback nor starts the muldiv unit.
    assign fire_acc  = fire & ~flush;
    assign md_fire   = fire_acc & issue_is_muldiv;

    assign rs1_haz = dec_uses_rs1 & (dec_rs1 != 5'd0) &
                     ((cnt[dec_rs1] != '0) | (issue_valid & issue_need_to_wb & (issue_rd == dec_rs1)));
    assign rs2_haz = dec_uses_rs2 & (dec_rs2 != 5'd0) &
                     ((cnt[dec_rs2] != '0) | (issue_valid & issue_need_to_wb & (issue_rd == dec_rs2)));
    assign rd_haz  = dec_need_to_wb & (dec_rd != 5'd0) & (cnt[dec_rd] == CNT_MAX);
    assign md_haz  = dec_is_muldiv & ((state == MD_BUSY) | (issue_valid & issue_is_muldiv));
    assign hazard  = rs1_haz | rs2_haz | rd_haz | md_haz;

    assign ibuffer_pop = reset_n & ~fifo_empty & slot_free & ~hazard & ~flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid      <= 1'b0;
            issue_rd         <= '0;
            issue_need_to_wb <= 1'b0;
            issue_is_muldiv  <= 1'b0;
            issue_pc         <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (ibuffer_pop) begin
            issue_valid      <= 1'b1;
            issue_rd         <= dec_rd;
            issue_need_to_wb <= dec_need_to_wb;
            issue_is_muldiv  <= dec_is_muldiv;
            issue_pc         <= dec_pc;
        end else if (fire) begin
            issue_valid <= 1'b0;
        end
    end

    // x0 is never written after reset, so it reads as zero forever.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++)
                cnt[r] <= sat_step(cnt[r],
                                   fire_acc & issue_need_to_wb & (issue_rd == 5'(r)),
                                   wb_valid & (wb_rd == 5'(r)));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (~fifo_empty & slot_free & hazard & ~flush)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (md_fire) state_nxt = MD_BUSY;
            MD_BUSY: if (md_done && !md_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus a randomized run, all checked
// against an outstanding-writes / busy-flag model of the issue stage.
module tb_decode_issue_ctrl;

    localparam int CNT_W = 2;
    localparam int SAT   = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fifo_empty;
    logic        ibuffer_pop;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_uses_rs1, dec_uses_rs2, dec_need_to_wb, dec_is_muldiv;
    logic [47:0] dec_pc;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic        issue_need_to_wb, issue_is_muldiv;
    logic [47:0] issue_pc;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        md_done, flush;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    decode_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .fifo_empty(fifo_empty), .ibuffer_pop(ibuffer_pop),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_need_to_wb(dec_need_to_wb), .dec_is_muldiv(dec_is_muldiv), .dec_pc(dec_pc),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .issue_need_to_wb(issue_need_to_wb), .issue_is_muldiv(issue_is_muldiv),
        .issue_pc(issue_pc), .wb_valid(wb_valid), .wb_rd(wb_rd), .md_done(md_done),
        .flush(flush), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // Reference model: held instruction, outstanding writes per register, muldiv busy flag.
    bit          m_valid, m_wb, m_md, m_busy;
    int          m_rd;
    logic [47:0] m_pc;
    int          m_cnt [32];
    int unsigned m_stall;

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_md = 0; m_busy = 0; m_rd = 0; m_pc = '0; m_stall = 0;
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    function automatic bit src_blocked(input int r);
        if (r == 0) return 0;
        return (m_cnt[r] > 0) || (m_valid && m_wb && m_rd == r);
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        if (dec_uses_rs1 && src_blocked(int'(dec_rs1))) h = 1;
        if (dec_uses_rs2 && src_blocked(int'(dec_rs2))) h = 1;
        if (dec_need_to_wb && dec_rd != 0 && m_cnt[dec_rd] >= SAT) h = 1;
        if (dec_is_muldiv && (m_busy || (m_valid && m_md))) h = 1;
        return h;
    endfunction

    function automatic bit m_pop();
        return reset_n && !fifo_empty && (!m_valid || issue_ready) && !m_hazard() && !flush;
    endfunction

    task automatic model_edge();
        bit pop  = m_pop();
        bit fire = m_valid && issue_ready;
        bit acc  = fire && !flush;
        bit hz   = m_hazard();
        bit sf   = !m_valid || issue_ready;
        for (int r = 1; r < 32; r++) begin
            bit inc = acc && m_wb && m_rd == r;
            bit dec = wb_valid && int'(wb_rd) == r;
            if (inc && !dec && m_cnt[r] < SAT) m_cnt[r]++;
            if (dec && !inc && m_cnt[r] > 0)   m_cnt[r]--;
        end
        if (acc && m_md) m_busy = 1;
        else if (md_done) m_busy = 0;
        if (!fifo_empty && sf && hz && !flush) m_stall++;
        if (flush) m_valid = 0;
        else if (pop) begin
            m_valid = 1; m_rd = int'(dec_rd); m_wb = dec_need_to_wb; m_md = dec_is_muldiv; m_pc = dec_pc;
        end else if (fire) m_valid = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        fifo_empty = 1; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
        dec_need_to_wb = 0; dec_is_muldiv = 0; dec_pc = '0; wb_valid = 0; wb_rd = 0;
        md_done = 0; flush = 0; issue_ready = 1;
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input bit u1, input bit u2,
                         input bit wb, input bit md, input logic [47:0] pc);
        fifo_empty = 0; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
        dec_uses_rs1 = u1; dec_uses_rs2 = u2; dec_need_to_wb = wb; dec_is_muldiv = md; dec_pc = pc;
    endtask

    // Retire everything outstanding so each scenario starts from a clean scoreboard.
    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 200; i++) begin
            bit busy = m_valid || m_busy;
            wb_valid = 0;
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0 && !wb_valid) begin
                wb_valid = 1; wb_rd = 5'(r); busy = 1;
            end
            md_done = m_busy;
            if (!busy) break;
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        drive(1, 2, 3, 1, 1, 1, 0, 48'h1000);
        repeat (2) @(negedge clock);
        #1;
        checks++; if (ibuffer_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", ibuffer_pop); end
        checks++; if (issue_valid !== 1'b0 || issue_rd !== 5'd0 || issue_pc !== 48'd0 ||
                      issue_need_to_wb !== 1'b0 || issue_is_muldiv !== 1'b0) begin
            errors++; $display("FAIL reset_issue: valid=%b rd=%0d pc=%h want all 0", issue_valid, issue_rd, issue_pc);
        end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        @(negedge clock);
        reset_n = 1;
        model_reset();
        idle_inputs();
        cycle();
    endtask

    task automatic test_back_to_back();
        drain();
        drive(3, 4, 1, 1, 1, 1, 0, 48'h2000);
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop1: got %b want 1", ibuffer_pop); end
        cycle();
        drive(3, 4, 2, 1, 1, 1, 0, 48'h2004);
        #1;
        checks++; if (ibuffer_pop !== 1'b1 || issue_valid !== 1'b1 || issue_rd !== 5'd1) begin
            errors++; $display("FAIL b2b_pop2: pop=%b valid=%b rd=%0d want 1 1 1", ibuffer_pop, issue_valid, issue_rd);
        end
        cycle();
        idle_inputs();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd2 || issue_pc !== 48'h2004 || dut.cnt[1] !== 2'd1) begin
            errors++; $display("FAIL b2b_second: valid=%b rd=%0d pc=%h cnt1=%0d want 1 2 2004 1",
                               issue_valid, issue_rd, issue_pc, dut.cnt[1]);
        end
        cycle();
        checks++; if (issue_valid !== 1'b0 || dut.cnt[1] !== 2'd1 || dut.cnt[2] !== 2'd1) begin
            errors++; $display("FAIL b2b_cnt: valid=%b cnt1=%0d cnt2=%0d want 0 1 1", issue_valid, dut.cnt[1], dut.cnt[2]);
        end
    endtask

    task automatic test_raw_stall();
        int unsigned base;
        drain();
        base = m_stall;
        drive(0, 0, 5, 0, 0, 1, 0, 48'h3000);
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL raw_popA: got %b want 1", ibuffer_pop); end
        cycle();
        drive(5, 0, 6, 1, 0, 1, 0, 48'h3004);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin wb_valid = 1; wb_rd = 5'd5; end
            #1;
            checks++; if (ibuffer_pop !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got %b want 0", i, ibuffer_pop); end
            cycle();
        end
        wb_valid = 0;
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL raw_release: got %b want 1", ibuffer_pop); end
        checks++; if (stall_cycles !== base + 4) begin errors++; $display("FAIL raw_stallcnt: got %0d want %0d", stall_cycles, base + 4); end
        cycle();
        idle_inputs();
        #1;
        checks++; if (issue_rd !== 5'd6 || issue_pc !== 48'h3004) begin errors++; $display("FAIL raw_issue: rd=%0d pc=%h want 6 3004", issue_rd, issue_pc); end
        cycle();
    endtask

    task automatic test_backpressure();
        drain();
        drive(0, 0, 9, 0, 0, 1, 0, 48'hA000_0000_0010);
        issue_ready = 0;
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL bp_pop: got %b want 1", ibuffer_pop); end
        cycle();
        drive(1, 2, 10, 1, 1, 1, 0, 48'hA000_0000_0014);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ibuffer_pop !== 1'b0 || issue_valid !== 1'b1 || issue_rd !== 5'd9 || issue_pc !== 48'hA000_0000_0010) begin
                errors++; $display("FAIL bp_hold%0d: pop=%b valid=%b rd=%0d pc=%h want 0 1 9 a00000000010",
                                   i, ibuffer_pop, issue_valid, issue_rd, issue_pc);
            end
            cycle();
        end
        issue_ready = 1;
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL bp_fire_pop: got %b want 1", ibuffer_pop); end
        cycle();
        idle_inputs();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_rd !== 5'd10 || issue_pc !== 48'hA000_0000_0014) begin
            errors++; $display("FAIL bp_next: valid=%b rd=%0d pc=%h want 1 10 a00000000014", issue_valid, issue_rd, issue_pc);
        end
        cycle();
    endtask

    task automatic test_muldiv();
        drain();
        drive(0, 0, 11, 0, 0, 1, 1, 48'h4000);
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL md_mul_pop: got %b want 1", ibuffer_pop); end
        cycle();
        drive(0, 0, 12, 0, 0, 1, 1, 48'h4004);
        for (int i = 0; i < 3; i++) begin
            md_done = (i == 2);
            #1;
            checks++; if (ibuffer_pop !== 1'b0) begin errors++; $display("FAIL md_div_stall%0d: got %b want 0", i, ibuffer_pop); end
            cycle();
        end
        md_done = 0;
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL md_div_pop: got %b want 1", ibuffer_pop); end
        cycle();
        idle_inputs();
        md_done = 1;
        cycle();
        md_done = 0;
        drive(0, 0, 13, 0, 0, 1, 1, 48'h4008);
        #1;
        checks++; if (ibuffer_pop !== 1'b0) begin errors++; $display("FAIL md_stay_busy: got %b want 0", ibuffer_pop); end
        cycle();
        md_done = 1;
        #1;
        checks++; if (ibuffer_pop !== 1'b0) begin errors++; $display("FAIL md_done_cycle: got %b want 0", ibuffer_pop); end
        cycle();
        md_done = 0;
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL md_mul3_pop: got %b want 1", ibuffer_pop); end
        cycle();
        idle_inputs();
        cycle();
    endtask

    task automatic test_saturation();
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 7, 0, 0, 1, 0, 48'h5000 + 48'(4 * i));
            #1;
            checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL sat_w%0d: got %b want 1", i, ibuffer_pop); end
            cycle();
        end
        idle_inputs();
        cycle();
        drive(0, 0, 7, 0, 0, 1, 0, 48'h500C);
        #1;
        checks++; if (dut.cnt[7] !== 2'd3 || ibuffer_pop !== 1'b0) begin
            errors++; $display("FAIL sat_full: cnt7=%0d pop=%b want 3 0", dut.cnt[7], ibuffer_pop);
        end
        cycle();
        wb_valid = 1; wb_rd = 5'd7;
        cycle();
        wb_valid = 0;
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL sat_w4_pop: got %b want 1", ibuffer_pop); end
        cycle();
        idle_inputs();
        wb_valid = 1; wb_rd = 5'd7;
        cycle();
        wb_valid = 0;
        #1;
        checks++; if (dut.cnt[7] !== 2'd2) begin errors++; $display("FAIL sat_fire_wb: cnt7=%0d want 2", dut.cnt[7]); end
    endtask

    task automatic test_flush_and_reset();
        drain();
        issue_ready = 0;
        drive(0, 0, 14, 0, 0, 1, 0, 48'h6000);
        cycle();
        drive(0, 0, 15, 0, 0, 1, 0, 48'h6004);
        flush = 1;
        #1;
        checks++; if (ibuffer_pop !== 1'b0 || issue_valid !== 1'b1) begin
            errors++; $display("FAIL flush_cycle: pop=%b valid=%b want 0 1", ibuffer_pop, issue_valid);
        end
        cycle();
        flush = 0;
        #1;
        checks++; if (issue_valid !== 1'b0 || dut.cnt[14] !== 2'd0 || ibuffer_pop !== 1'b1) begin
            errors++; $display("FAIL flush_after: valid=%b cnt14=%0d pop=%b want 0 0 1", issue_valid, dut.cnt[14], ibuffer_pop);
        end
        cycle();
        drain();
        drive(0, 0, 16, 0, 0, 1, 1, 48'h7000);
        cycle();
        drive(16, 0, 17, 1, 0, 1, 1, 48'h7004);
        repeat (3) cycle();
        #2;
        reset_n = 0;
        #1;
        checks++; if (issue_valid !== 1'b0 || issue_rd !== 5'd0 || issue_pc !== 48'd0 || issue_is_muldiv !== 1'b0 ||
                      issue_need_to_wb !== 1'b0 || stall_cycles !== 32'd0 || ibuffer_pop !== 1'b0) begin
            errors++; $display("FAIL midreset: valid=%b rd=%0d pc=%h md=%b stall=%0d pop=%b want all 0",
                               issue_valid, issue_rd, issue_pc, issue_is_muldiv, stall_cycles, ibuffer_pop);
        end
        @(negedge clock);
        reset_n = 1;
        model_reset();
        #1;
        checks++; if (ibuffer_pop !== 1'b1) begin errors++; $display("FAIL postreset_pop: got %b want 1", ibuffer_pop); end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            int bad = -1;
            fifo_empty     = ($urandom_range(0, 3) == 0);
            dec_rs1        = 5'($urandom_range(0, 7));
            dec_rs2        = 5'($urandom_range(0, 7));
            dec_rd         = 5'($urandom_range(0, 7));
            dec_uses_rs1   = 1'($urandom);
            dec_uses_rs2   = 1'($urandom);
            dec_need_to_wb = ($urandom_range(0, 3) != 0);
            dec_is_muldiv  = ($urandom_range(0, 4) == 0);
            dec_pc         = 48'({$urandom, $urandom});
            issue_ready    = ($urandom_range(0, 9) < 7);
            wb_valid       = 1'($urandom);
            wb_rd          = 5'($urandom_range(0, 7));
            md_done        = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            flush          = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (ibuffer_pop !== m_pop()) begin errors++; $display("FAIL rnd_pop@%0d: got %b want %b", i, ibuffer_pop, m_pop()); end
            cycle();
            checks++; if (issue_valid !== m_valid || issue_rd !== 5'(m_rd) || issue_need_to_wb !== m_wb ||
                          issue_is_muldiv !== m_md || issue_pc !== m_pc) begin
                errors++; $display("FAIL rnd_issue@%0d: valid=%b rd=%0d wb=%b md=%b pc=%h want %b %0d %b %b %h", i,
                                   issue_valid, issue_rd, issue_need_to_wb, issue_is_muldiv, issue_pc,
                                   m_valid, m_rd, m_wb, m_md, m_pc);
            end
            checks++; if (stall_cycles !== m_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, stall_cycles, m_stall); end
            for (int r = 0; r < 32; r++) if (int'(dut.cnt[r]) != m_cnt[r]) bad = r;
            checks++; if (bad >= 0) begin
                errors++; $display("FAIL rnd_cnt@%0d: cnt[%0d]=%0d want %0d", i, bad, dut.cnt[bad], m_cnt[bad]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_backpressure();
        test_muldiv();
        test_saturation();
        test_flush_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of each per-register pending-writeback counter; saturation value is 2^CNT_W-1.
REQ-002 SHALL have ports, clock and reset first:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  instruction buffer empty.
- ibuffer_pop  out  1  pops the buffer head this cycle.
- dec_rs1, dec_rs2, dec_rd  in  5 each  decoded register indices.
- dec_uses_rs1, dec_uses_rs2  in  1 each  source reads a register.
- dec_need_to_wb  in  1  instruction writes rd.
- dec_is_muldiv  in  1  OR of decoded muldiv type bits.
- dec_pc  in  48  instruction PC.
- issue_valid  out  1  output register holds an instruction.
- issue_ready  in  1  downstream accepts.
- issue_rd  out  5  registered rd.
- issue_need_to_wb  out  1  registered need_to_wb.
- issue_is_muldiv  out  1  registered muldiv flag.
- issue_pc  out  48  registered PC.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  5  writeback register.
- md_done  in  1  one-cycle pulse when the muldiv unit completes.
- flush  in  1  redirect; discard the unissued instruction.
- stall_cycles  out  32  hazard-stall performance counter.

Function
REQ-003 SHALL compute fire = issue_valid & issue_ready, and slot_free = ~issue_valid | fire.
REQ-004 SHALL assert hazard when any of the following holds:
- (dec_uses_rs1 & dec_rs1≠0 & (cnt[dec_rs1]≠0 | held-match(dec_rs1)))
- the same condition for rs2
- dec_need_to_wb & dec_rd≠0 & cnt[dec_rd] saturated
- dec_is_muldiv & (state=MD_BUSY | (issue_valid & issue_is_muldiv))
REQ-005 SHALL define held-match(r) = issue_valid & issue_need_to_wb & issue_rd=r.
REQ-006 SHALL assert ibuffer_pop combinationally iff ~fifo_empty & slot_free & ~hazard & ~flush.
REQ-007 SHALL, on pop, load dec_rd, dec_need_to_wb, dec_is_muldiv and dec_pc into the issue_* registers and set issue_valid=1 on the next edge; latency from pop to issue_valid is 1 cycle.
REQ-008 SHALL clear issue_valid on the next edge on fire without pop, or on flush; flush takes priority over fire and pop.
REQ-009 SHALL hold all issue_* outputs stable while issue_valid & ~issue_ready.
REQ-010 SHALL update scoreboard counter cnt[r] (r=1..31) once per cycle:
- +1 on fire & issue_need_to_wb & issue_rd=r
- -1 on wb_valid & wb_rd=r
- unchanged when both occur in the same cycle
REQ-011 SHALL keep cnt[0] at 0, ignore decrements at 0, and never increment past saturation.
REQ-012 SHALL leave the scoreboard unchanged on flush; in-flight writebacks still retire.
REQ-013 SHALL implement a two-state FSM, IDLE and MD_BUSY:
- IDLE -> MD_BUSY on fire & issue_is_muldiv.
- MD_BUSY -> IDLE on md_done without a new muldiv fire.
- md_done together with a muldiv fire in the same cycle: stay MD_BUSY.
- flush does not change the state.
REQ-014 SHALL increment stall_cycles each cycle with ~fifo_empty & slot_free & hazard & ~flush; it wraps modulo 2^32.
REQ-015 SHALL not issue non-muldiv instructions differently in MD_BUSY versus IDLE.

Reset
REQ-016 SHALL, while reset_n=0 and asynchronously, set issue_valid=0, issue_rd=0, issue_need_to_wb=0, issue_is_muldiv=0, issue_pc=0, all cnt=0, state=IDLE, stall_cycles=0.
REQ-017 SHALL hold ibuffer_pop=0 during reset; reset asserted mid-stall or mid-MD_BUSY discards all state.

Verification
REQ-018 Back-to-back independent ADDs (rd=1, rd=2) with issue_ready=1 -> one pop per cycle, issue_valid continuous, cnt[1]=cnt[2]=1 after fire.
REQ-019 Write x5, then read x5 with no writeback -> second pop withheld and stall_cycles counts each cycle; wb_valid with wb_rd=5 -> pop occurs the cycle after cnt[5] returns to 0.
REQ-020 issue_ready=0 for 3 cycles -> issue_pc/issue_rd stable and no pop; issue_ready=1 -> fire and the next pop happen in the same cycle.
REQ-021 MUL issued, then DIV queued -> DIV stalls until md_done; md_done together with a new MUL fire -> state stays MD_BUSY.
REQ-022 Saturation (CNT_W=2) with 3 outstanding writes to x7 -> a 4th writer of x7 stalls; fire and wb to x7 in the same cycle -> cnt[7] unchanged.
REQ-023 flush while issue_valid=1 & issue_ready=0 -> issue_valid=0 next cycle, no pop that cycle, cnt unchanged; reset_n low mid-sequence -> all outputs 0 immediately.
